polaris_aclint: RTL and testbench

POLARIS_ACLINT -- requirements
Module: polaris_aclint

---
 rtl/polaris_aclint.sv | 266 ++++++++++++++++++++++++++
 tb/tb_polaris_aclint.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polaris_aclint.sv
// polaris_aclint: RISC-V ACLINT (MSWI, MTIMER, SSWI) behind a TileLink-UH slave port.
//
// Ports:
//   aclint_clk_i    sole clock, rising edge
//   aclint_rst_i    synchronous active-high reset
//   tluh_i          TL-UH A channel from the master
//   aclint_d_ready  D-channel ready from the master
//   tluh_o          TL-UH D channel to the master
//   aclint_a_ready  A-channel ready
//   hart_mti        machine timer interrupt per hart (registered compare)
//   hart_msip       machine software interrupt per hart
//   hart_ssip       one-cycle supervisor software interrupt set pulse per hart
//   mtime_o         current mtime value
//
// Register map (16-bit address):
//   0x0000 + 4h      MSIP[h]
//   0x4000 + 8h      MTIMECMP[h] low, +4 high
//   0xBFF8 / 0xBFFC  MTIME low / high
//   0xC000 + 4h      SETSSIP[h] (write-only pulse, reads 0)

package tluh;
    // Source field is carried at this fixed width; the slave honours the low TL_RS bits.
    localparam int SRC_W = 8;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH_DATA  = 3'd2;
    localparam logic [2:0] LOGIC_DATA  = 3'd3;
    localparam logic [2:0] GET         = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic             a_valid;
        logic [2:0]       a_opcode;
        logic [2:0]       a_param;
        logic [2:0]       a_size;
        logic [SRC_W-1:0] a_source;
        logic [15:0]      a_address;
        logic [3:0]       a_mask;
        logic [31:0]      a_data;
        logic             a_corrupt;
    } tluh_m2s;

    typedef struct packed {
        logic             d_valid;
        logic [2:0]       d_opcode;
        logic [1:0]       d_param;
        logic [2:0]       d_size;
        logic [SRC_W-1:0] d_source;
        logic             d_sink;
        logic             d_denied;
        logic [31:0]      d_data;
        logic             d_corrupt;
    } tluh_s2m;
endpackage

module polaris_aclint #(
    parameter int HARTNO   = 2,
    parameter int TICK_DIV = 1,
    parameter int TL_RS    = 4
) (
    input  logic                aclint_clk_i,
    input  logic                aclint_rst_i,
    input  tluh::tluh_m2s       tluh_i,
    input  logic                aclint_d_ready,
    output tluh::tluh_s2m       tluh_o,
    output logic                aclint_a_ready,
    output logic [HARTNO-1:0]   hart_mti,
    output logic [HARTNO-1:0]   hart_msip,
    output logic [HARTNO-1:0]   hart_ssip,
    output logic [63:0]         mtime_o
);

    localparam int SW = tluh::SRC_W;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SRC_MASK   = (TL_RS >= SW) ? {SW{1'b1}}
                                                         : SW'((64'd1 << TL_RS) - 64'd1);

    typedef enum logic [1:0] {R_MSIP, R_CMP, R_MTIME, R_SSIP} region_e;

    logic [63:0]       mtime;
    logic [PW-1:0]     presc;
    logic [HARTNO-1:0] msip;
    logic [63:0]       mtimecmp [HARTNO];

    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_size;
    logic [SW-1:0]     d_source;
    logic              d_denied;
    logic [31:0]       d_data;

    region_e           region;
    logic [12:0]       hidx;
    logic              hi_half;
    logic              param_ok;
    logic              legal;
    logic [31:0]       old_val;
    logic [31:0]       new_val;
    logic              accept;
    logic              do_write;
    logic              tick;

    assign aclint_a_ready = !d_valid | aclint_d_ready;
    assign accept         = tluh_i.a_valid & aclint_a_ready;
    assign tick           = (presc == PRESC_LAST);

    // Address decode: every address falls in one region; holes are caught by the hart range check.
    always_comb begin
        region  = R_SSIP;
        hidx    = '0;
        hi_half = tluh_i.a_address[2];
        if (tluh_i.a_address < 16'h4000) begin
            region = R_MSIP;
            hidx   = {1'b0, tluh_i.a_address[13:2]};
        end else if (tluh_i.a_address < 16'hBFF8) begin
            region = R_CMP;
            hidx   = tluh_i.a_address[15:3] - 13'h0800;
        end else if (tluh_i.a_address < 16'hC000) begin
            region = R_MTIME;
        end else begin
            hidx   = {1'b0, tluh_i.a_address[13:2]};
        end
    end

    always_comb begin
        param_ok = 1'b0;
        case (tluh_i.a_opcode)
            tluh::PUT_FULL, tluh::PUT_PARTIAL, tluh::GET: param_ok = (tluh_i.a_param == 3'd0);
            tluh::ARITH_DATA:                             param_ok = (tluh_i.a_param <= 3'd4);
            tluh::LOGIC_DATA:                             param_ok = (tluh_i.a_param <= 3'd3);
            default:                                      param_ok = 1'b0;
        endcase
        legal = param_ok && (tluh_i.a_size == 3'd2) && (tluh_i.a_address[1:0] == 2'b00)
                && !tluh_i.a_corrupt && ((region == R_MTIME) || (hidx < 13'(HARTNO)));
    end

    always_comb begin
        old_val = '0;
        if (region == R_MTIME) begin
            old_val = hi_half ? mtime[63:32] : mtime[31:0];
        end
        for (int h = 0; h < HARTNO; h++) begin
            if (hidx == 13'(h)) begin
                if (region == R_MSIP) begin
                    old_val = {31'b0, msip[h]};
                end else if (region == R_CMP) begin
                    old_val = hi_half ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
                end
            end
        end
    end

    // Value to be written back; atomics operate on the full word.
    always_comb begin
        new_val = old_val;
        case (tluh_i.a_opcode)
            tluh::PUT_FULL: new_val = tluh_i.a_data;
            tluh::PUT_PARTIAL: begin
                for (int b = 0; b < 4; b++) begin
                    new_val[8*b +: 8] = tluh_i.a_mask[b] ? tluh_i.a_data[8*b +: 8]
                                                          : old_val[8*b +: 8];
                end
            end
            tluh::ARITH_DATA: begin
                case (tluh_i.a_param)
                    3'd0:    new_val = ($signed(tluh_i.a_data) < $signed(old_val)) ? tluh_i.a_data : old_val;
                    3'd1:    new_val = ($signed(tluh_i.a_data) > $signed(old_val)) ? tluh_i.a_data : old_val;
                    3'd2:    new_val = (tluh_i.a_data < old_val) ? tluh_i.a_data : old_val;
                    3'd3:    new_val = (tluh_i.a_data > old_val) ? tluh_i.a_data : old_val;
                    3'd4:    new_val = old_val + tluh_i.a_data;
                    default: new_val = old_val;
                endcase
            end
            tluh::LOGIC_DATA: begin
                case (tluh_i.a_param)
                    3'd0:    new_val = old_val ^ tluh_i.a_data;
                    3'd1:    new_val = old_val | tluh_i.a_data;
                    3'd2:    new_val = old_val & tluh_i.a_data;
                    3'd3:    new_val = tluh_i.a_data;
                    default: new_val = old_val;
                endcase
            end
            default: new_val = old_val;
        endcase
    end

    assign do_write = accept && legal && (tluh_i.a_opcode != tluh::GET);

    always_ff @(posedge aclint_clk_i) begin
        if (aclint_rst_i) begin
            mtime     <= '0;
            presc     <= '0;
            msip      <= '0;
            hart_mti  <= '0;
            hart_ssip <= '0;
            d_valid   <= 1'b0;
            d_opcode  <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= '0;
            for (int h = 0; h < HARTNO; h++) begin
                mtimecmp[h] <= '1;
            end
        end else begin
            presc <= tick ? '0 : presc + PW'(1);

            // A bus write to either mtime half wins over the tick for that cycle.
            if (do_write && region == R_MTIME) begin
                if (hi_half) mtime[63:32] <= new_val;
                else         mtime[31:0]  <= new_val;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            hart_ssip <= '0;
            for (int h = 0; h < HARTNO; h++) begin
                if (do_write && hidx == 13'(h)) begin
                    case (region)
                        R_MSIP: msip[h] <= new_val[0];
                        R_CMP: begin
                            if (hi_half) mtimecmp[h][63:32] <= new_val;
                            else         mtimecmp[h][31:0]  <= new_val;
                        end
                        R_SSIP:  hart_ssip[h] <= new_val[0];
                        default: ;
                    endcase
                end
                hart_mti[h] <= (mtime >= mtimecmp[h]);
            end

            if (accept) begin
                d_valid  <= 1'b1;
                d_opcode <= (tluh_i.a_opcode == tluh::PUT_FULL || tluh_i.a_opcode == tluh::PUT_PARTIAL ||
                             !param_ok) && tluh_i.a_opcode != tluh::GET &&
                            tluh_i.a_opcode != tluh::ARITH_DATA && tluh_i.a_opcode != tluh::LOGIC_DATA
                            ? tluh::ACCESS_ACK : tluh::ACCESS_ACK_DATA;
                d_size   <= tluh_i.a_size;
                d_source <= tluh_i.a_source & SRC_MASK;
                d_denied <= !legal;
                d_data   <= (legal && tluh_i.a_opcode != tluh::PUT_FULL &&
                             tluh_i.a_opcode != tluh::PUT_PARTIAL) ? old_val : 32'd0;
            end else if (aclint_d_ready) begin
                d_valid  <= 1'b0;
            end
        end
    end

    always_comb begin
        tluh_o           = '0;
        tluh_o.d_valid   = d_valid;
        tluh_o.d_opcode  = d_opcode;
        tluh_o.d_size    = d_size;
        tluh_o.d_source  = d_source;
        tluh_o.d_denied  = d_denied;
        tluh_o.d_data    = d_data;
    end

    assign hart_msip = msip;
    assign mtime_o   = mtime;

endmodule

// File: tb/tb_polaris_aclint.sv
// tb_polaris_aclint: scoreboard bench for polaris_aclint (HARTNO=2, TICK_DIV=4).
// Expected D beats are queued as A beats are accepted and compared as they complete.

module tb_polaris_aclint;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_ready = 1'b1;
    tluh::tluh_m2s a_req;
    tluh::tluh_s2m d_rsp;
    logic          a_ready;
    logic [1:0]    mti;
    logic [1:0]    msip;
    logic [1:0]    ssip;
    logic [63:0]   mtime;

    always #5 clk = ~clk;

    polaris_aclint #(.HARTNO(2), .TICK_DIV(4), .TL_RS(4)) dut (
        .aclint_clk_i   (clk),
        .aclint_rst_i   (rst),
        .tluh_i         (a_req),
        .aclint_d_ready (d_ready),
        .tluh_o         (d_rsp),
        .aclint_a_ready (a_ready),
        .hart_mti       (mti),
        .hart_msip      (msip),
        .hart_ssip      (ssip),
        .mtime_o        (mtime)
    );

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [2:0]  size;
        logic        denied;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                         input logic [7:0] src, input logic [15:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic corrupt);
        a_req.a_valid   = 1'b1;
        a_req.a_opcode  = op;
        a_req.a_param   = param;
        a_req.a_size    = size;
        a_req.a_source  = src;
        a_req.a_address = addr;
        a_req.a_mask    = mask;
        a_req.a_data    = data;
        a_req.a_corrupt = corrupt;
    endtask

    // Waits for the handshake of the beat currently on the A channel and queues its response.
    task automatic wait_accept(input logic exp_den, input logic [31:0] exp_data);
        exp_t e;
        int   cyc = 0;
        e.op     = (a_req.a_opcode <= 3'd1) ? 3'd0 : 3'd1;
        e.src    = a_req.a_source;
        e.size   = a_req.a_size;
        e.denied = exp_den;
        e.data   = exp_data;
        @(negedge clk);
        while (!a_ready) begin
            cyc++;
            if (cyc > 50) begin
                chk("accept_timeout", 64'd0, 64'd1);
                a_req.a_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                        input logic [7:0] src, input logic [15:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic corrupt,
                        input logic exp_den, input logic [31:0] exp_data);
        drive(op, param, size, src, addr, mask, data, corrupt);
        wait_accept(exp_den, exp_data);
    endtask

    task automatic idle();
        a_req.a_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 40) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && d_rsp.d_valid && d_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_d_beat", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("d_opcode", 64'(d_rsp.d_opcode), 64'(mon_e.op));
                chk("d_source", 64'(d_rsp.d_source), 64'(mon_e.src));
                chk("d_size",   64'(d_rsp.d_size),   64'(mon_e.size));
                chk("d_denied", 64'(d_rsp.d_denied), 64'(mon_e.denied));
                chk("d_data",   64'(d_rsp.d_data),   64'(mon_e.data));
                chk("d_zero_fields", 64'({d_rsp.d_param, d_rsp.d_sink, d_rsp.d_corrupt}), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        a_req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mtime",   mtime, 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_d_valid", 64'(d_rsp.d_valid), 64'd0);
        chk("rst_mti",     64'(mti), 64'd0);
        chk("rst_msip",    64'(msip), 64'd0);
        chk("rst_ssip",    64'(ssip), 64'd0);

        // Free-running timer with the divide-by-4 prescaler.
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mtime_after_40", mtime, 64'd10);
        chk("mti_idle", 64'(mti), 64'd0);

        // Hart 0 compare = 20.
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd1, 16'h4000, 4'hF, 32'd20, 1'b0, 1'b0, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd2, 16'h4004, 4'hF, 32'd0,  1'b0, 1'b0, 32'd0);
        idle();
        begin
            int cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (mtime != 64'd20 && cyc < 200);
        end
        chk("mtime_reach_20", mtime, 64'd20);
        chk("mti0_before_rise", 64'(mti[0]), 64'd0);
        @(negedge clk);
        chk("mti0_rise", 64'(mti[0]), 64'd1);
        chk("mti1_low", 64'(mti[1]), 64'd0);

        // MSIP via atomic OR, then read back.
        @(posedge clk); #1;
        send(tluh::LOGIC_DATA, 3'd1, 3'd2, 8'd3, 16'h0004, 4'hF, 32'd1, 1'b0, 1'b0, 32'd0);
        chk("msip_after_or", 64'(msip), 64'b10);
        send(tluh::GET, 3'd0, 3'd2, 8'd4, 16'h0004, 4'hF, 32'd0, 1'b0, 1'b0, 32'd1);

        // SETSSIP pulse.
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd5, 16'hC000, 4'hF, 32'd1, 1'b0, 1'b0, 32'd0);
        idle();
        chk("ssip_pulse", 64'(ssip), 64'b01);
        @(posedge clk); #1;
        chk("ssip_cleared", 64'(ssip), 64'b00);
        send(tluh::GET, 3'd0, 3'd2, 8'd6, 16'hC000, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0);

        // Denied accesses leave state unchanged.
        send(tluh::GET,      3'd0, 3'd2, 8'd7, 16'h4010, 4'hF, 32'd0, 1'b0, 1'b1, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd1, 8'd8, 16'h0004, 4'hF, 32'd0, 1'b0, 1'b1, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd9, 16'h0006, 4'hF, 32'd0, 1'b0, 1'b1, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd10, 16'h0004, 4'hF, 32'd0, 1'b1, 1'b1, 32'd0);
        send(tluh::LOGIC_DATA, 3'd4, 3'd2, 8'd11, 16'h0004, 4'hF, 32'd0, 1'b0, 1'b1, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd12, 16'hC008, 4'hF, 32'd1, 1'b0, 1'b1, 32'd0);
        idle();
        chk("msip_after_denied", 64'(msip), 64'b10);
        chk("ssip_after_denied", 64'(ssip), 64'b00);
        send(tluh::GET, 3'd0, 3'd2, 8'd13, 16'h4000, 4'hF, 32'd0, 1'b0, 1'b0, 32'd20);

        // Partial write and arithmetic atomics on hart 1 compare low.
        send(tluh::PUT_PARTIAL, 3'd0, 3'd2, 8'd14, 16'h4008, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        send(tluh::GET,        3'd0, 3'd2, 8'd15, 16'h4008, 4'hF, 32'd0, 1'b0, 1'b0, 32'hFFFF_5678);
        send(tluh::ARITH_DATA, 3'd4, 3'd2, 8'd1,  16'h4008, 4'hF, 32'd1, 1'b0, 1'b0, 32'hFFFF_5678);
        send(tluh::ARITH_DATA, 3'd2, 3'd2, 8'd2,  16'h4008, 4'hF, 32'h10, 1'b0, 1'b0, 32'hFFFF_5679);
        send(tluh::ARITH_DATA, 3'd1, 3'd2, 8'd3,  16'h4008, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h10);
        send(tluh::LOGIC_DATA, 3'd0, 3'd2, 8'd4,  16'h4008, 4'hF, 32'h3, 1'b0, 1'b0, 32'h10);
        send(tluh::GET,        3'd0, 3'd2, 8'd5,  16'h4008, 4'hF, 32'd0, 1'b0, 1'b0, 32'h13);
        idle();
        drain();

        // Back-pressure on D, then two back-to-back beats.
        @(posedge clk); #1 d_ready = 1'b0;
        send(tluh::GET, 3'd0, 3'd2, 8'd3, 16'h4000, 4'hF, 32'd0, 1'b0, 1'b0, 32'd20);
        drive(tluh::GET, 3'd0, 3'd2, 8'd5, 16'h4004, 4'hF, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_a_ready",  64'(a_ready), 64'd0);
            chk("stall_d_valid",  64'(d_rsp.d_valid), 64'd1);
            chk("stall_d_source", 64'(d_rsp.d_source), 64'd3);
            chk("stall_d_data",   64'(d_rsp.d_data), 64'd20);
        end
        @(posedge clk); #1 d_ready = 1'b1;
        wait_accept(1'b0, 32'd0);
        send(tluh::GET, 3'd0, 3'd2, 8'd9, 16'h0004, 4'hF, 32'd0, 1'b0, 1'b0, 32'd1);
        idle();
        drain();

        // mtime wrap and all-ones compare boundary.
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd6, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        send(tluh::PUT_FULL, 3'd0, 3'd2, 8'd7, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        idle();
        chk("mtime_all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("mti_at_max", 64'(mti), 64'b11);
        begin
            int cyc = 0;
            while (mtime == 64'hFFFF_FFFF_FFFF_FFFF && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("mtime_wrap", mtime, 64'd0);
        drain();

        // Reset with a response pending drops it.
        @(posedge clk); #1 d_ready = 1'b0;
        drive(tluh::GET, 3'd0, 3'd2, 8'd7, 16'h0004, 4'hF, 32'd0, 1'b0);
        @(posedge clk); #1;
        idle();
        chk("pending_d_valid", 64'(d_rsp.d_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drop_d_valid", 64'(d_rsp.d_valid), 64'd0);
        chk("rst_drop_a_ready", 64'(a_ready), 64'd1);
        chk("rst_drop_mtime",   mtime, 64'd0);
        chk("rst_drop_msip",    64'(msip), 64'd0);
        chk("rst_drop_mti",     64'(mti), 64'd0);
        rst = 1'b0;
        d_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_beat_after_rst", 64'(d_rsp.d_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
